// File: rtl/unidad_secuenciador_pipeline_pkg.sv
// Shared types and constants for the pipeline sequencer.
package unidad_secuenciador_pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } estado_e;

  // Stages behind IF/ID that must retire after a HALT is accepted.
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_W      = 2;
  localparam int REG_CERO     = 0;

endpackage

// File: rtl/unidad_secuenciador_pipeline_riesgos.sv
// Combinational load-use hazard comparator.
module unidad_deteccion_riesgos
  import unidad_secuenciador_pipeline_pkg::*;
#(
  parameter int REGS = 5
) (
  input  logic            i_ID_EX_MemRead,
  input  logic [REGS-1:0] i_ID_EX_Rt,
  input  logic [REGS-1:0] i_IF_ID_Rs,
  input  logic [REGS-1:0] i_IF_ID_Rt,
  output logic            o_stall
);

  logic rt_no_cero;
  logic coincide;

  // Register 0 is hardwired; a load into it never creates a dependency.
  assign rt_no_cero = (i_ID_EX_Rt != REGS'(REG_CERO));
  assign coincide   = (i_ID_EX_Rt == i_IF_ID_Rs) || (i_ID_EX_Rt == i_IF_ID_Rt);
  assign o_stall    = i_ID_EX_MemRead & rt_no_cero & coincide;

endmodule

// File: rtl/unidad_secuenciador_pipeline.sv
// Central sequencer: execution modes, hazard stalls, branch flushes, halt drain.
module unidad_secuenciador_pipeline
  import unidad_secuenciador_pipeline_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int REGS  = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_modo_step,
  input  logic             i_step,
  input  logic             i_halt,
  input  logic             i_ID_EX_MemRead,
  input  logic [REGS-1:0]  i_ID_EX_Rt,
  input  logic [REGS-1:0]  i_IF_ID_Rs,
  input  logic [REGS-1:0]  i_IF_ID_Rt,
  input  logic             i_EX_MEM_Branch,
  input  logic             i_EX_MEM_Cero,
  output logic             o_PC_enable,
  output logic             o_IF_ID_enable,
  output logic             o_IF_ID_flush,
  output logic             o_ID_EX_flush,
  output logic             o_EX_MEM_flush,
  output logic             o_etapas_enable,
  output logic [2:0]       o_estado,
  output logic             o_halted,
  output logic [NBITS-1:0] o_ciclos
);

  estado_e             estado_q, estado_d;
  logic                modo_q, modo_d;
  logic                step_q;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [NBITS-1:0]    ciclos_q;

  logic step_rise;
  logic advance;
  logic stall_raw;
  logic branch_taken;
  logic stall;
  logic halt_acc;

  unidad_deteccion_riesgos #(
    .REGS(REGS)
  ) u_riesgos (
    .i_ID_EX_MemRead (i_ID_EX_MemRead),
    .i_ID_EX_Rt      (i_ID_EX_Rt),
    .i_IF_ID_Rs      (i_IF_ID_Rs),
    .i_IF_ID_Rt      (i_IF_ID_Rt),
    .o_stall         (stall_raw)
  );

  assign step_rise = i_step & ~step_q;

  always_comb begin
    advance = 1'b0;
    case (estado_q)
      ST_RUN:   advance = 1'b1;
      ST_STEP:  advance = step_rise;
      ST_DRAIN: advance = modo_q ? step_rise : 1'b1;
      default:  advance = 1'b0;
    endcase
  end

  // A taken branch outranks everything: the halt/stall seen now are wrong-path.
  assign branch_taken = advance & i_EX_MEM_Branch & i_EX_MEM_Cero;
  assign stall        = advance & stall_raw & ~branch_taken;
  assign halt_acc     = advance & i_halt & ~branch_taken & ~stall &
                        ((estado_q == ST_RUN) || (estado_q == ST_STEP));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      estado_q <= ST_IDLE;
      modo_q   <= 1'b0;
      step_q   <= 1'b0;
      drain_q  <= '0;
      ciclos_q <= '0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      step_q   <= i_step;
      drain_q  <= drain_d;
      if (advance && !(&ciclos_q)) begin
        ciclos_q <= ciclos_q + NBITS'(1);
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    drain_d  = drain_q;
    case (estado_q)
      ST_IDLE: begin
        if (i_run) begin
          modo_d   = i_modo_step;
          estado_d = i_modo_step ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (halt_acc) begin
          estado_d = ST_DRAIN;
          drain_d  = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (advance) begin
          drain_d = drain_q - DRAIN_W'(1);
          if (drain_d == '0) begin
            estado_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: estado_d = ST_HALTED;
      default:   estado_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_PC_enable     = 1'b0;
    o_IF_ID_enable  = 1'b0;
    o_IF_ID_flush   = 1'b0;
    o_ID_EX_flush   = 1'b0;
    o_EX_MEM_flush  = 1'b0;
    o_etapas_enable = 1'b0;
    if (advance) begin
      if (estado_q == ST_DRAIN) begin
        o_IF_ID_enable  = 1'b1;
        o_IF_ID_flush   = 1'b1;
        o_etapas_enable = 1'b1;
      end else if (branch_taken) begin
        o_PC_enable     = 1'b1;
        o_IF_ID_enable  = 1'b1;
        o_etapas_enable = 1'b1;
        o_IF_ID_flush   = 1'b1;
        o_ID_EX_flush   = 1'b1;
        o_EX_MEM_flush  = 1'b1;
      end else if (stall) begin
        o_ID_EX_flush   = 1'b1;
        o_etapas_enable = 1'b1;
      end else if (halt_acc) begin
        o_IF_ID_enable  = 1'b1;
        o_IF_ID_flush   = 1'b1;
        o_etapas_enable = 1'b1;
      end else begin
        o_PC_enable     = 1'b1;
        o_IF_ID_enable  = 1'b1;
        o_etapas_enable = 1'b1;
      end
    end
  end

  assign o_estado = estado_q;
  assign o_halted = (estado_q == ST_HALTED);
  assign o_ciclos = ciclos_q;

endmodule

// File: tb/tb_unidad_secuenciador_pipeline.sv
// Scoreboard bench for the pipeline sequencer.
module tb_unidad_secuenciador_pipeline;

  localparam int NBITS = 32;
  localparam int REGS  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             run, modo_step, step, halt;
  logic             memread;
  logic [REGS-1:0]  idex_rt, ifid_rs, ifid_rt;
  logic             branch, cero;
  logic             pc_en, ifid_en, ifid_fl, idex_fl, exmem_fl, etapas_en;
  logic [2:0]       estado;
  logic             halted;
  logic [NBITS-1:0] ciclos;

  typedef struct {
    string      name;
    logic [9:0] v;
    logic [NBITS-1:0] c;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  unidad_secuenciador_pipeline #(
    .NBITS(NBITS),
    .REGS (REGS)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_run           (run),
    .i_modo_step     (modo_step),
    .i_step          (step),
    .i_halt          (halt),
    .i_ID_EX_MemRead (memread),
    .i_ID_EX_Rt      (idex_rt),
    .i_IF_ID_Rs      (ifid_rs),
    .i_IF_ID_Rt      (ifid_rt),
    .i_EX_MEM_Branch (branch),
    .i_EX_MEM_Cero   (cero),
    .o_PC_enable     (pc_en),
    .o_IF_ID_enable  (ifid_en),
    .o_IF_ID_flush   (ifid_fl),
    .o_ID_EX_flush   (idex_fl),
    .o_EX_MEM_flush  (exmem_fl),
    .o_etapas_enable (etapas_en),
    .o_estado        (estado),
    .o_halted        (halted),
    .o_ciclos        (ciclos)
  );

  // Monitor: outputs are combinational, so each pushed expectation is
  // compared at the negedge following the stimulus that produced it.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e   = q.pop_front();
      got = {pc_en, ifid_en, ifid_fl, idex_fl, exmem_fl, etapas_en, estado, halted};
      n_checks++;
      if (got !== e.v || ciclos !== e.c) begin
        n_errors++;
        $display("FAIL %s: got ctl=%b ciclos=%0d, expected ctl=%b ciclos=%0d",
                 e.name, got, ciclos, e.v, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input bit pc, input bit ie, input bit ifl,
                     input bit idfl, input bit exfl, input bit et, input logic [2:0] est,
                     input bit hal, input int cic);
    exp_t e;
    e.name = name;
    e.v    = {pc, ie, ifl, idfl, exfl, et, est, hal};
    e.c    = NBITS'(cic);
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; run = 0; modo_step = 0; step = 0; halt = 0;
    memread = 0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0; branch = 0; cero = 0;
    tick();
    chk("reset", 0,0,0,0,0,0, 3'd0, 0, 0);
    tick();
    rst = 0; run = 1; modo_step = 0;
    chk("idle_run", 0,0,0,0,0,0, 3'd0, 0, 0);
    tick();
    run = 0;
    chk("run_c0", 1,1,0,0,0,1, 3'd1, 0, 0);
    tick();
    chk("run_c1", 1,1,0,0,0,1, 3'd1, 0, 1);
    tick();
    memread = 1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
    chk("stall_rs", 0,0,0,1,0,1, 3'd1, 0, 2);
    tick();
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    chk("rt0_nostall", 1,1,0,0,0,1, 3'd1, 0, 3);
    tick();
    idex_rt = 5'd9; ifid_rs = 5'd1; ifid_rt = 5'd9;
    chk("stall_rt", 0,0,0,1,0,1, 3'd1, 0, 4);
    tick();
    ifid_rs = 5'd9; branch = 1; cero = 1;
    chk("branch_over_stall", 1,1,1,1,1,1, 3'd1, 0, 5);
    tick();
    halt = 1;
    chk("branch_over_halt", 1,1,1,1,1,1, 3'd1, 0, 6);
    tick();
    branch = 1; cero = 0;
    chk("stall_blocks_halt", 0,0,0,1,0,1, 3'd1, 0, 7);
    tick();
    memread = 0; branch = 0;
    chk("halt_accept", 0,1,1,0,0,1, 3'd1, 0, 8);
    tick();
    halt = 0;
    chk("drain1", 0,1,1,0,0,1, 3'd3, 0, 9);
    tick();
    chk("drain2", 0,1,1,0,0,1, 3'd3, 0, 10);
    tick();
    chk("drain3", 0,1,1,0,0,1, 3'd3, 0, 11);
    tick();
    chk("halted", 0,0,0,0,0,0, 3'd4, 1, 12);
    tick();
    run = 1; halt = 1;
    chk("halted_run", 0,0,0,0,0,0, 3'd4, 1, 12);
    tick();
    run = 0; halt = 0;
    chk("halted_stay", 0,0,0,0,0,0, 3'd4, 1, 12);

    tick();
    rst = 1;
    chk("reset2", 0,0,0,0,0,0, 3'd0, 0, 0);
    tick();
    rst = 0; run = 1; modo_step = 1;
    chk("idle_step", 0,0,0,0,0,0, 3'd0, 0, 0);
    tick();
    run = 0; modo_step = 0; step = 1;
    chk("step_rise", 1,1,0,0,0,1, 3'd2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_hold", 0,0,0,0,0,0, 3'd2, 0, 1);
    end
    tick();
    step = 0;
    chk("step_low", 0,0,0,0,0,0, 3'd2, 0, 1);
    tick();
    step = 1;
    chk("step_rise2", 1,1,0,0,0,1, 3'd2, 0, 1);
    tick();
    step = 0;
    chk("step_low2", 0,0,0,0,0,0, 3'd2, 0, 2);
    tick();
    step = 1; halt = 1;
    chk("step_halt", 0,1,1,0,0,1, 3'd2, 0, 2);
    tick();
    step = 0; halt = 0;
    chk("sdrain_wait", 0,0,0,0,0,0, 3'd3, 0, 3);
    tick();
    step = 1;
    chk("sdrain_adv", 0,1,1,0,0,1, 3'd3, 0, 3);
    tick();
    chk("sdrain_hold", 0,0,0,0,0,0, 3'd3, 0, 4);
    tick();
    // Reset lands mid-cycle; the next negedge precedes any clock edge.
    rst = 1;
    chk("async_reset", 0,0,0,0,0,0, 3'd0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unidad_secuenciador_pipeline.md
Name: unidad_secuenciador_pipeline

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Generates PC enable, plus enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles run/step/halt execution modes, load-use stalls and taken-branch flushes.
- Counts executed cycles for the debug unit.

Parameters:
- NBITS, 32, width of the cycle counter.
- REGS, 5, register-index width.

Ports:
- i_clk  in  1  system clock; state updates on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_run  in  1  level; start execution from IDLE.
- i_modo_step  in  1  1 = step mode, 0 = continuous; sampled when leaving IDLE.
- i_step  in  1  step request; internally rising-edge detected.
- i_halt  in  1  HALT opcode decoded in the IF/ID instruction.
- i_ID_EX_MemRead  in  1  ID/EX stage holds a load.
- i_ID_EX_Rt  in  REGS  load destination register.
- i_IF_ID_Rs  in  REGS  source register of the decoding instruction.
- i_IF_ID_Rt  in  REGS  source register of the decoding instruction.
- i_EX_MEM_Branch  in  1  branch flag held in EX/MEM.
- i_EX_MEM_Cero  in  1  ALU zero flag held in EX/MEM.
- o_PC_enable  out  1  PC loads next value.
- o_IF_ID_enable  out  1  IF/ID captures.
- o_IF_ID_flush  out  1  IF/ID loads a bubble.
- o_ID_EX_flush  out  1  ID/EX control fields are zeroed.
- o_EX_MEM_flush  out  1  EX/MEM control fields are zeroed.
- o_etapas_enable  out  1  ID/EX, EX/MEM and MEM/WB capture.
- o_estado  out  3  current FSM state.
- o_halted  out  1  program finished.
- o_ciclos  out  NBITS  count of advance cycles.

Behaviour:
- Reset (async): state IDLE, step_q 0, drain counter 0, o_ciclos 0. All enables and flushes 0. o_halted 0.
- Outputs are combinational from state and inputs. They are valid within the posedge half-cycle, ahead of the negedge capture in the pipeline registers.
- States and transitions:
  - IDLE: i_run=1 goes to RUN if i_modo_step=0, else STEP. The mode bit is latched.
  - RUN: advance=1 every cycle.
  - STEP: advance=1 only in the cycle where i_step rises (i_step=1 & step_q=0). Holding i_step high yields exactly one advance.
  - DRAIN: entered when advance & i_halt are accepted. The drain counter is loaded with 3. Each advance cycle decrements it; at 0 the FSM goes to HALTED. In step mode the drain advances only on step pulses.
  - HALTED: o_halted=1 and all enables are 0. Only i_reset leaves this state; i_run and i_step are ignored.
- Base outputs when advance=1: o_PC_enable=1, o_IF_ID_enable=1, o_etapas_enable=1.
- When advance=0: all enables are 0 and all flushes are 0 (the pipeline freezes intact).
- Taken branch (advance & i_EX_MEM_Branch & i_EX_MEM_Cero):
  - o_IF_ID_flush=1, o_ID_EX_flush=1, o_EX_MEM_flush=1.
  - PC is still enabled, so the external mux selects the branch target.
  - Highest priority: it masks both load-use and halt (wrong-path halt is ignored).
- Load-use stall (advance & i_ID_EX_MemRead & i_ID_EX_Rt!=0 & (Rt==i_IF_ID_Rs | Rt==i_IF_ID_Rt), no taken branch):
  - o_PC_enable=0, o_IF_ID_enable=0, o_ID_EX_flush=1. o_etapas_enable stays 1.
  - i_halt is not accepted in a stall cycle; it is re-evaluated next cycle.
- Halt acceptance (advance & i_halt, no branch, no stall):
  - o_PC_enable=0 and o_IF_ID_flush=1 from this cycle until HALTED.
- In DRAIN, fetch stays off: o_PC_enable=0, o_IF_ID_flush=1, o_etapas_enable=advance.
- o_ciclos increments on every advance cycle and saturates at all-ones.
- Reset mid-operation returns immediately to IDLE. There is no drain on reset.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
  - DRAIN_CYCLES=3.
  - Constant register index 0.
- Sub-module unidad_deteccion_riesgos: purely combinational load-use comparator producing o_stall. Instantiated once.

Test Plan:
- Reset, then i_run=1, i_modo_step=0 -> next cycle o_estado=1; all enables 1; o_ciclos increments 0,1,2,...
- RUN with i_ID_EX_MemRead=1, Rt=5, IF_ID_Rs=5 -> o_PC_enable=0, o_IF_ID_enable=0, o_ID_EX_flush=1, o_etapas_enable=1. Rt=0 with Rs=0 -> no stall.
- Same cycle: load-use condition plus Branch=1, Cero=1 -> three flushes asserted, o_PC_enable=1, no stall.
- Continuous mode, i_halt=1 -> DRAIN with o_PC_enable=0. After exactly 3 cycles o_halted=1 and o_estado=4. Later i_run pulses have no effect.
- Step mode, i_step held high 5 cycles -> exactly one advance, o_ciclos +1. A second rising edge gives +1 again.
- Assert i_reset asynchronously during DRAIN -> outputs go to reset values before the next clock edge; o_ciclos=0.
